alu_error_stats: RTL and testbench

Downstream error-metrics stage for the approximate ALU study. Consumes the 17-bit result of the exact ALU and of an approximate ALU for the same operands. Over a programmed window of N samples it computes per-sample error distance (ED = |y_exact − y_approx|) and accumulates error count, ED sum and maximum ED. The totals are presented to the characterisation bench, from which mean ED and error rate are derived.

---
 rtl/alu_error_stats_if.sv | 31 +++
 rtl/alu_error_stats.sv | 148 ++++++++++++++
 tb/tb_alu_error_stats.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_error_stats_if.sv
// Bundle between the characterisation bench and the ALU error-metrics stage.
// The bench side drives the window control and ALU result pairs; the stats
// side returns flow control, status and the accumulated window totals.
interface alu_error_stats_if #(
   parameter int WIDTH = 17,
   parameter int CNT_W = 16,
   parameter int SUM_W = 32
);
   logic             start;
   logic [CNT_W-1:0] n_samples;
   logic             in_valid;
   logic [WIDTH-1:0] y_exact;
   logic [WIDTH-1:0] y_approx;
   logic             in_ready;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] sample_count;
   logic [CNT_W-1:0] err_count;
   logic [SUM_W-1:0] sum_ed;
   logic [WIDTH-1:0] max_ed;

   modport master (
      output start, n_samples, in_valid, y_exact, y_approx,
      input  in_ready, busy, done, sample_count, err_count, sum_ed, max_ed
   );

   modport slave (
      input  start, n_samples, in_valid, y_exact, y_approx,
      output in_ready, busy, done, sample_count, err_count, sum_ed, max_ed
   );
endinterface

// File: rtl/alu_error_stats.sv
// Error-metrics stage for the approximate ALU study. Over a window of N
// result pairs it computes the error distance |y_exact - y_approx| of each
// pair in a first register stage, then accumulates error count, saturating
// ED sum and maximum ED. Totals hold until the next accepted start.
module alu_error_stats #(
   parameter int WIDTH = 17,
   parameter int CNT_W = 16,
   parameter int SUM_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   alu_error_stats_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Unsigned magnitude of the difference between two results.
   function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] d;
      if (a >= b) d = a - b;
      else        d = b - a;
      return d;
   endfunction

   // Add a zero-extended ED to the sum, clamping at all-ones on overflow.
   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] acc,
                                                input logic [WIDTH-1:0] ed);
      logic [SUM_W:0] s;
      s = {1'b0, acc} + {{(SUM_W+1-WIDTH){1'b0}}, ed};
      if (s[SUM_W]) return {SUM_W{1'b1}};
      else          return s[SUM_W-1:0];
   endfunction

   state_t           state_r;
   state_t           state_s;
   logic             start_ok_s;
   logic             hs_s;
   logic             last_s;

   logic [CNT_W-1:0] n_lat_r;
   logic [CNT_W-1:0] sample_count_r;
   logic [WIDTH-1:0] ed_r;
   logic             ed_valid_r;
   logic [CNT_W-1:0] err_count_r;
   logic [SUM_W-1:0] sum_ed_r;
   logic [WIDTH-1:0] max_ed_r;
   logic             in_ready_r;
   logic             busy_r;
   logic             done_r;

   // Window FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_s;
   end

   // Next-state logic plus start acceptance and handshake qualification.
   always_comb begin
      state_s    = state_r;
      start_ok_s = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
      hs_s       = bus.in_valid && in_ready_r && (state_r == ST_RUN);
      last_s     = hs_s && ((sample_count_r + CNT_ONE) == n_lat_r);
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start_ok_s) begin
               if (bus.n_samples == '0) state_s = ST_DONE;
               else                     state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_s) state_s = ST_DRAIN;
            else        state_s = ST_RUN;
         end
         ST_DRAIN: state_s = ST_DONE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Status outputs registered from the upcoming state so they align with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         in_ready_r <= (state_s == ST_RUN);
         busy_r     <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
         done_r     <= (state_s == ST_DONE);
      end
   end

   // Window length latch, sample counter and stage-1 ED register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_lat_r        <= '0;
         sample_count_r <= '0;
         ed_r           <= '0;
         ed_valid_r     <= 1'b0;
      end else if (start_ok_s) begin
         n_lat_r        <= bus.n_samples;
         sample_count_r <= '0;
         ed_r           <= '0;
         ed_valid_r     <= 1'b0;
      end else if (hs_s) begin
         sample_count_r <= sample_count_r + CNT_ONE;
         ed_r           <= abs_diff(bus.y_exact, bus.y_approx);
         ed_valid_r     <= 1'b1;
      end else begin
         ed_valid_r     <= 1'b0;
      end
   end

   // Accumulate stage: fold each valid stage-1 ED into the window totals.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count_r <= '0;
         sum_ed_r    <= '0;
         max_ed_r    <= '0;
      end else if (start_ok_s) begin
         err_count_r <= '0;
         sum_ed_r    <= '0;
         max_ed_r    <= '0;
      end else if (ed_valid_r) begin
         if (ed_r != '0) err_count_r <= err_count_r + CNT_ONE;
         sum_ed_r <= sat_add(sum_ed_r, ed_r);
         if (ed_r > max_ed_r) max_ed_r <= ed_r;
      end
   end

   assign bus.in_ready     = in_ready_r;
   assign bus.busy         = busy_r;
   assign bus.done         = done_r;
   assign bus.sample_count = sample_count_r;
   assign bus.err_count    = err_count_r;
   assign bus.sum_ed       = sum_ed_r;
   assign bus.max_ed       = max_ed_r;

endmodule

// File: tb/tb_alu_error_stats.sv
// Directed bench for alu_error_stats: a table of measurement windows with
// hand-computed totals, plus sequences for reset, start and saturation corners.
module tb_alu_error_stats;

   logic clk;
   logic rst;

   alu_error_stats_if #(.WIDTH(17), .CNT_W(16), .SUM_W(32)) bus1 ();
   alu_error_stats_if #(.WIDTH(17), .CNT_W(16), .SUM_W(18)) bus2 ();

   alu_error_stats #(.WIDTH(17), .CNT_W(16), .SUM_W(32)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   alu_error_stats #(.WIDTH(17), .CNT_W(16), .SUM_W(18)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   typedef struct {
      logic [15:0]      n;
      logic [3:0]       gap;
      logic [3:0][16:0] ye;
      logic [3:0][16:0] ya;
      logic [15:0]      e_cnt;
      logic [15:0]      e_err;
      logic [31:0]      e_sum;
      logic [16:0]      e_max;
   } vec_t;

   vec_t vecs [4];
   int   n_total;
   int   n_pass;

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total = n_total + 1;
      if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      else             n_pass = n_pass + 1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Opens a window, feeds the pairs and stops in the done cycle after checking totals.
   task automatic run_window(input vec_t v);
      bus1.start     = 1'b1;
      bus1.n_samples = v.n;
      step();
      bus1.start = 1'b0;
      chk("rdy_after_start", 64'(bus1.in_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         if (i < int'(v.n)) begin
            if (v.gap[i]) begin
               bus1.in_valid = 1'b0;
               step();
            end
            bus1.in_valid = 1'b1;
            bus1.y_exact  = v.ye[i];
            bus1.y_approx = v.ya[i];
            step();
         end
      end
      // keep offering a pair after the last one; it must not be taken
      bus1.y_exact  = 17'd7;
      bus1.y_approx = 17'd0;
      chk("rdy_after_last", 64'(bus1.in_ready), 64'd0);
      chk("busy_after_last", 64'(bus1.busy), 64'd1);
      chk("done_early", 64'(bus1.done), 64'd0);
      step();
      bus1.in_valid = 1'b0;
      chk("done_pulse", 64'(bus1.done), 64'd1);
      chk("sample_count", 64'(bus1.sample_count), 64'(v.e_cnt));
      chk("err_count", 64'(bus1.err_count), 64'(v.e_err));
      chk("sum_ed", 64'(bus1.sum_ed), 64'(v.e_sum));
      chk("max_ed", 64'(bus1.max_ed), 64'(v.e_max));
   endtask

   task automatic check_idle_after_done();
      step();
      chk("done_cleared", 64'(bus1.done), 64'd0);
      chk("busy_idle", 64'(bus1.busy), 64'd0);
      chk("rdy_idle", 64'(bus1.in_ready), 64'd0);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;

      vecs[0] = '{n: 16'd3, gap: 4'b0000,
                  ye: {17'd0, 17'd19, 17'd143, 17'd76},
                  ya: {17'd0, 17'd19, 17'd143, 17'd76},
                  e_cnt: 16'd3, e_err: 16'd0, e_sum: 32'd0, e_max: 17'd0};
      vecs[1] = '{n: 16'd4, gap: 4'b0110,
                  ye: {17'h1FFFF, 17'd100, 17'd36, 17'd62},
                  ya: {17'd0, 17'd100, 17'd40, 17'd60},
                  e_cnt: 16'd4, e_err: 16'd3, e_sum: 32'd131077, e_max: 17'h1FFFF};
      vecs[2] = '{n: 16'd2, gap: 4'b0000,
                  ye: {17'd0, 17'd0, 17'd9, 17'd5},
                  ya: {17'd0, 17'd0, 17'd5, 17'd9},
                  e_cnt: 16'd2, e_err: 16'd2, e_sum: 32'd8, e_max: 17'd4};
      vecs[3] = '{n: 16'd1, gap: 4'b0001,
                  ye: {17'd0, 17'd0, 17'd0, 17'd0},
                  ya: {17'd0, 17'd0, 17'd0, 17'd1},
                  e_cnt: 16'd1, e_err: 16'd1, e_sum: 32'd1, e_max: 17'd1};

      rst            = 1'b1;
      bus1.start     = 1'b0;
      bus1.n_samples = 16'd0;
      bus1.in_valid  = 1'b0;
      bus1.y_exact   = 17'd0;
      bus1.y_approx  = 17'd0;
      bus2.start     = 1'b0;
      bus2.n_samples = 16'd0;
      bus2.in_valid  = 1'b0;
      bus2.y_exact   = 17'd0;
      bus2.y_approx  = 17'd0;
      step();
      step();
      chk("rst_in_ready", 64'(bus1.in_ready), 64'd0);
      chk("rst_busy", 64'(bus1.busy), 64'd0);
      chk("rst_done", 64'(bus1.done), 64'd0);
      chk("rst_sample_count", 64'(bus1.sample_count), 64'd0);
      chk("rst_err_count", 64'(bus1.err_count), 64'd0);
      chk("rst_sum_ed", 64'(bus1.sum_ed), 64'd0);
      chk("rst_max_ed", 64'(bus1.max_ed), 64'd0);
      rst = 1'b0;
      step();

      // table of windows
      for (int k = 0; k < 4; k++) begin
         run_window(vecs[k]);
         check_idle_after_done();
      end

      // n_samples == 0: done on the cycle after start, results cleared
      bus1.start     = 1'b1;
      bus1.n_samples = 16'd0;
      step();
      bus1.start = 1'b0;
      chk("n0_done", 64'(bus1.done), 64'd1);
      chk("n0_busy", 64'(bus1.busy), 64'd0);
      chk("n0_sample_count", 64'(bus1.sample_count), 64'd0);
      chk("n0_err_count", 64'(bus1.err_count), 64'd0);
      chk("n0_sum_ed", 64'(bus1.sum_ed), 64'd0);
      chk("n0_max_ed", 64'(bus1.max_ed), 64'd0);
      check_idle_after_done();

      // start in the DONE cycle opens a fresh window
      run_window(vecs[2]);
      bus1.start     = 1'b1;
      bus1.n_samples = 16'd2;
      step();
      bus1.start = 1'b0;
      chk("dstart_rdy", 64'(bus1.in_ready), 64'd1);
      chk("dstart_cleared_cnt", 64'(bus1.sample_count), 64'd0);
      chk("dstart_cleared_sum", 64'(bus1.sum_ed), 64'd0);
      bus1.in_valid = 1'b1;
      bus1.y_exact  = 17'd10;
      bus1.y_approx = 17'd4;
      step();
      bus1.y_exact  = 17'd4;
      bus1.y_approx = 17'd10;
      step();
      bus1.in_valid = 1'b0;
      step();
      chk("dstart_done", 64'(bus1.done), 64'd1);
      chk("dstart_err", 64'(bus1.err_count), 64'd2);
      chk("dstart_sum", 64'(bus1.sum_ed), 64'd12);
      chk("dstart_max", 64'(bus1.max_ed), 64'd6);
      check_idle_after_done();

      // start pulsed mid-window is ignored
      bus1.start     = 1'b1;
      bus1.n_samples = 16'd3;
      step();
      bus1.in_valid  = 1'b1;
      bus1.y_exact   = 17'd1;
      bus1.y_approx  = 17'd0;
      bus1.start     = 1'b0;
      step();
      bus1.start     = 1'b1;
      bus1.n_samples = 16'd1;
      step();
      bus1.start = 1'b0;
      chk("rstart_still_run", 64'(bus1.in_ready), 64'd1);
      step();
      bus1.in_valid = 1'b0;
      chk("rstart_rdy_drop", 64'(bus1.in_ready), 64'd0);
      step();
      chk("rstart_done", 64'(bus1.done), 64'd1);
      chk("rstart_count", 64'(bus1.sample_count), 64'd3);
      chk("rstart_sum", 64'(bus1.sum_ed), 64'd3);
      check_idle_after_done();

      // reset mid-window discards the partial window
      bus1.start     = 1'b1;
      bus1.n_samples = 16'd4;
      step();
      bus1.start    = 1'b0;
      bus1.in_valid = 1'b1;
      bus1.y_exact  = 17'd50;
      bus1.y_approx = 17'd20;
      step();
      step();
      bus1.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mrst_in_ready", 64'(bus1.in_ready), 64'd0);
      chk("mrst_busy", 64'(bus1.busy), 64'd0);
      chk("mrst_sample_count", 64'(bus1.sample_count), 64'd0);
      chk("mrst_err_count", 64'(bus1.err_count), 64'd0);
      chk("mrst_sum_ed", 64'(bus1.sum_ed), 64'd0);
      chk("mrst_max_ed", 64'(bus1.max_ed), 64'd0);
      #2;
      rst = 1'b0;
      step();
      bus1.start     = 1'b1;
      bus1.n_samples = 16'd1;
      step();
      bus1.start    = 1'b0;
      bus1.in_valid = 1'b1;
      bus1.y_exact  = 17'd3;
      bus1.y_approx = 17'd1;
      step();
      bus1.in_valid = 1'b0;
      step();
      chk("post_rst_done", 64'(bus1.done), 64'd1);
      chk("post_rst_count", 64'(bus1.sample_count), 64'd1);
      chk("post_rst_sum", 64'(bus1.sum_ed), 64'd2);
      chk("post_rst_max", 64'(bus1.max_ed), 64'd2);
      check_idle_after_done();

      // 18-bit sum saturates
      bus2.start     = 1'b1;
      bus2.n_samples = 16'd3;
      step();
      bus2.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus2.in_valid = 1'b1;
         bus2.y_exact  = 17'h1FFFF;
         bus2.y_approx = 17'd0;
         step();
      end
      bus2.in_valid = 1'b0;
      step();
      chk("sat_done", 64'(bus2.done), 64'd1);
      chk("sat_sum", 64'(bus2.sum_ed), 64'h3FFFF);
      chk("sat_max", 64'(bus2.max_ed), 64'h1FFFF);
      chk("sat_err", 64'(bus2.err_count), 64'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
